// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one bus master's request/ack channel into the arbiter.
// The master modport belongs to the requester. The slave modport belongs to the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [1:0]        memwrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wd;
  logic              ack;
  logic [DATA_W-1:0] rd;

  modport master (output req, memwrite, addr, wd, input ack, rd);
  modport slave  (input req, memwrite, addr, wd, output ack, rd);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM bus between two masters (port 0 = core,
// port 1 = loader/DMA). Each transfer runs IDLE -> ISSUE -> (WAIT) -> RESP.
// RAM commands, acks and read data all come straight from flops.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
// The default build uses round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_n_reset,
  mem_arbiter_if.slave      io_m0,
  mem_arbiter_if.slave      io_m1,
  output logic [1:0]        o_ram_memwrite,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wd,
  input  logic [DATA_W-1:0] i_ram_rd,
  output logic              o_busy,
  output logic              o_owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // Extra WAIT cycles beyond the first; only meaningful when RD_LAT > 1.
  localparam logic [1:0] WAIT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_is_rd;
  logic [1:0]        r_wait_cnt;
  logic [1:0]        r_ram_memwrite;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wd;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [DATA_W-1:0] r_m0_rd;
  logic [DATA_W-1:0] r_m1_rd;

  logic              w_grant;
  logic              w_grant_port;
  logic [1:0]        w_cmd_memwrite;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] w_cmd_wd;

  assign w_cmd_memwrite = w_grant_port ? io_m1.memwrite : io_m0.memwrite;
  assign w_cmd_addr     = w_grant_port ? io_m1.addr     : io_m0.addr;
  assign w_cmd_wd       = w_grant_port ? io_m1.wd       : io_m0.wd;

  // Next-state and arbitration decision. A grant is only made in IDLE or RESP.
  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_grant_port = r_owner;
    case (r_state)
      S_IDLE: begin
        if (io_m0.req || io_m1.req) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
`ifdef MEM_ARB_FIXED_PRIO_EN
          w_grant_port = !io_m0.req;
`else
          if (io_m0.req && io_m1.req) w_grant_port = !r_owner;
          else                        w_grant_port = io_m1.req;
`endif
        end
      end
      S_ISSUE: w_next = (RD_LAT > 1) ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (r_wait_cnt == 2'd0) w_next = S_RESP;
      end
      S_RESP: begin
        // The owner's req is still its current request here, so only the
        // other port can be handed the bus directly.
        w_next = S_IDLE;
`ifdef MEM_ARB_FIXED_PRIO_EN
        // Port 1 never takes over from port 0 while port 0 still holds req.
        // Port 0 then wins again in IDLE.
        if (r_owner && io_m0.req) begin
          w_grant      = 1'b1;
          w_grant_port = 1'b0;
          w_next       = S_ISSUE;
        end else if (!r_owner && io_m1.req && !io_m0.req) begin
          w_grant      = 1'b1;
          w_grant_port = 1'b1;
          w_next       = S_ISSUE;
        end
`else
        if (r_owner ? io_m0.req : io_m1.req) begin
          w_grant      = 1'b1;
          w_grant_port = !r_owner;
          w_next       = S_ISSUE;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_n_reset) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // RAM command registers. memwrite is only nonzero in the cycle after a grant (ISSUE).
  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      r_ram_memwrite <= 2'b00;
      r_ram_addr     <= '0;
      r_ram_wd       <= '0;
      r_owner        <= 1'b1;
      r_is_rd        <= 1'b0;
    end else begin
      r_ram_memwrite <= 2'b00;
      if (w_grant) begin
        r_ram_memwrite <= w_cmd_memwrite;
        r_ram_addr     <= w_cmd_addr;
        r_ram_wd       <= w_cmd_wd;
        r_owner        <= w_grant_port;
        r_is_rd        <= (w_cmd_memwrite == 2'b00);
      end
    end
  end

  // Read-latency counter, loaded in ISSUE and counting down through WAIT.
  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      r_wait_cnt <= 2'd0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= WAIT_LOAD;
    end else if (r_state == S_WAIT && r_wait_cnt != 2'd0) begin
      r_wait_cnt <= r_wait_cnt - 2'd1;
    end
  end

  // Ack pulse and read-data capture on the edge that enters RESP.
  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m0_rd  <= '0;
      r_m1_rd  <= '0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      if (w_next == S_RESP) begin
        if (r_owner) begin
          r_m1_ack <= 1'b1;
          if (r_is_rd) r_m1_rd <= i_ram_rd;
        end else begin
          r_m0_ack <= 1'b1;
          if (r_is_rd) r_m0_rd <= i_ram_rd;
        end
      end
    end
  end

  assign o_ram_memwrite = r_ram_memwrite;
  assign o_ram_addr     = r_ram_addr;
  assign o_ram_wd       = r_ram_wd;
  assign o_busy         = (r_state != S_IDLE);
  assign o_owner        = r_owner;
  assign io_m0.ack      = r_m0_ack;
  assign io_m1.ack      = r_m1_ack;
  assign io_m0.rd       = r_m0_rd;
  assign io_m1.rd       = r_m1_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// It uses two instances: RD_LAT=1 (id base 0) and RD_LAT=3 (id base 2). Expected
// acks are queued as {id = 2*dut + port, read data, cycle}. A negedge monitor
// pops and compares them. Honours MEM_ARB_FIXED_PRIO_EN for the contention case.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic n_reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Cycle index k is the interval after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1_m0 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1_m1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3_m0 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3_m1 ();

  logic [1:0]  ram1_mw, ram3_mw;
  logic [31:0] ram1_addr, ram3_addr, ram1_wd, ram3_wd, ram1_rd, ram3_rd;
  logic        busy1, busy3, owner1, owner3;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_n_reset(n_reset), .io_m0(if1_m0), .io_m1(if1_m1),
    .o_ram_memwrite(ram1_mw), .o_ram_addr(ram1_addr), .o_ram_wd(ram1_wd),
    .i_ram_rd(ram1_rd), .o_busy(busy1), .o_owner(owner1));

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_n_reset(n_reset), .io_m0(if3_m0), .io_m1(if3_m1),
    .o_ram_memwrite(ram3_mw), .o_ram_addr(ram3_addr), .o_ram_wd(ram3_wd),
    .i_ram_rd(ram3_rd), .o_busy(busy3), .o_owner(owner3));

  // Shared RAM model: the read path follows the registered address. Only the RD_LAT=1 instance writes.
  logic [31:0] mem [0:255];
  assign ram1_rd = mem[ram1_addr[9:2]];
  assign ram3_rd = mem[ram3_addr[9:2]];

  always @(posedge clk) begin
    if (cyc == 0) begin
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'h0;
    end else if (ram1_mw == 2'b11) begin
      mem[ram1_addr[9:2]] <= ram1_wd;
    end
  end

  typedef struct {
    int          id;
    logic [31:0] rd;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [31:0] rd, input int c);
    exp_t e;
    e.id  = id;
    e.rd  = rd;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv(input int id, input logic rq, input logic [1:0] mw,
                     input logic [31:0] a, input logic [31:0] wd);
    case (id)
      0: begin if1_m0.req = rq; if1_m0.memwrite = mw; if1_m0.addr = a; if1_m0.wd = wd; end
      1: begin if1_m1.req = rq; if1_m1.memwrite = mw; if1_m1.addr = a; if1_m1.wd = wd; end
      2: begin if3_m0.req = rq; if3_m0.memwrite = mw; if3_m0.addr = a; if3_m0.wd = wd; end
      default: begin if3_m1.req = rq; if3_m1.memwrite = mw; if3_m1.addr = a; if3_m1.wd = wd; end
    endcase
  endtask

  // Monitor: every ack seen on any port is matched against the scoreboard front.
  logic [3:0]  acks;
  logic [31:0] mon_rd;
  exp_t        mon_e;
  assign acks = {if3_m1.ack, if3_m0.ack, if1_m1.ack, if1_m0.ack};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (acks[i]) begin
        case (i)
          0: mon_rd = if1_m0.rd;
          1: mon_rd = if1_m1.rd;
          2: mon_rd = if3_m0.rd;
          default: mon_rd = if3_m1.rd;
        endcase
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: id %0d acked at cycle %0d, none expected", i, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("ack_id", 64'(i), 64'(mon_e.id));
          check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("ack_rd", 64'(mon_rd), 64'(mon_e.rd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  int t;

  initial begin
    n_reset = 1'b0;
    for (int i = 0; i < 4; i++) drv(i, 1'b0, 2'b00, 32'h0, 32'h0);
    wait_cyc(3);

    // Reset state of both instances.
    check("rst1_mw", 64'(ram1_mw), 64'd0);
    check("rst1_addr", 64'(ram1_addr), 64'd0);
    check("rst1_wd", 64'(ram1_wd), 64'd0);
    check("rst1_busy", 64'(busy1), 64'd0);
    check("rst1_owner", 64'(owner1), 64'd1);
    check("rst1_acks", 64'(acks), 64'd0);
    check("rst1_rd", 64'({if1_m0.rd, if1_m1.rd}), 64'd0);
    check("rst3_busy", 64'(busy3), 64'd0);
    check("rst3_owner", 64'(owner3), 64'd1);
    n_reset = 1'b1;
    wait_cyc(1);

    // m0 reads 0x10 (DEADBEEF): ISSUE at t+1, ack at t+2.
    t = cyc;
    drv(0, 1'b1, 2'b00, 32'h10, 32'h0);
    push(0, 32'hDEADBEEF, t + 2);
    wait_cyc(1);
    check("rd_issue_mw", 64'(ram1_mw), 64'd0);
    check("rd_issue_addr", 64'(ram1_addr), 64'h10);
    check("rd_issue_busy", 64'(busy1), 64'd1);
    check("rd_issue_owner", 64'(owner1), 64'd0);
    wait_cyc(2);
    drv(0, 1'b0, 2'b00, 32'h10, 32'h0);
    check("rd_done_busy", 64'(busy1), 64'd0);
    wait_cyc(1);

    // m1 word-writes CAFEF00D to 0x20; m1_rd stays at 0.
    t = cyc;
    drv(1, 1'b1, 2'b11, 32'h20, 32'hCAFEF00D);
    push(1, 32'h0, t + 2);
    wait_cyc(1);
    check("wr_issue_mw", 64'(ram1_mw), 64'd3);
    check("wr_issue_addr", 64'(ram1_addr), 64'h20);
    check("wr_issue_wd", 64'(ram1_wd), 64'hCAFEF00D);
    check("wr_issue_owner", 64'(owner1), 64'd1);
    wait_cyc(1);
    check("wr_resp_mw", 64'(ram1_mw), 64'd0);
    wait_cyc(1);
    drv(1, 1'b0, 2'b11, 32'h20, 32'hCAFEF00D);
    wait_cyc(1);

    // m0 reads back the written word.
    t = cyc;
    drv(0, 1'b1, 2'b00, 32'h20, 32'h0);
    push(0, 32'hCAFEF00D, t + 2);
    wait_cyc(3);
    drv(0, 1'b0, 2'b00, 32'h20, 32'h0);
    wait_cyc(1);

    // Both ports request continuously straight after a reset.
    n_reset = 1'b0;
    wait_cyc(1);
    check("rst2_owner", 64'(owner1), 64'd1);
    check("rst2_m0_rd", 64'(if1_m0.rd), 64'd0);
    n_reset = 1'b1;
    wait_cyc(1);
    t = cyc;
    drv(0, 1'b1, 2'b00, 32'h10, 32'h0);
    drv(1, 1'b1, 2'b00, 32'h20, 32'h0);
`ifdef MEM_ARB_FIXED_PRIO_EN
    push(0, 32'hDEADBEEF, t + 2);
    push(0, 32'hDEADBEEF, t + 5);
    push(0, 32'hDEADBEEF, t + 8);
    push(1, 32'hCAFEF00D, t + 11);
    wait_cyc(9);
    drv(0, 1'b0, 2'b00, 32'h10, 32'h0);
    wait_cyc(3);
    drv(1, 1'b0, 2'b00, 32'h20, 32'h0);
`else
    push(0, 32'hDEADBEEF, t + 2);
    push(1, 32'hCAFEF00D, t + 4);
    push(0, 32'hDEADBEEF, t + 6);
    push(1, 32'hCAFEF00D, t + 8);
    wait_cyc(7);
    drv(0, 1'b0, 2'b00, 32'h10, 32'h0);
    wait_cyc(2);
    drv(1, 1'b0, 2'b00, 32'h20, 32'h0);
`endif
    wait_cyc(2);

    // RD_LAT=3 instance: ISSUE, WAIT, WAIT, RESP; ack 3 cycles after ISSUE.
    t = cyc;
    drv(2, 1'b1, 2'b00, 32'h10, 32'h0);
    push(2, 32'hDEADBEEF, t + 4);
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(1);
      check("lat3_busy", 64'(busy3), 64'd1);
      if (k == 1) check("lat3_issue_addr", 64'(ram3_addr), 64'h10);
      if (k == 2) check("lat3_wait_mw", 64'(ram3_mw), 64'd0);
    end
    wait_cyc(1);
    drv(2, 1'b0, 2'b00, 32'h10, 32'h0);
    check("lat3_done_busy", 64'(busy3), 64'd0);
    wait_cyc(1);

    // Reset dropped during WAIT: transfer abandoned, no ack, reset values.
    t = cyc;
    drv(3, 1'b1, 2'b00, 32'h20, 32'h0);
    wait_cyc(2);
    check("abort_wait_busy", 64'(busy3), 64'd1);
    n_reset = 1'b0;
    wait_cyc(1);
    check("abort_busy", 64'(busy3), 64'd0);
    check("abort_owner", 64'(owner3), 64'd1);
    check("abort_addr", 64'(ram3_addr), 64'd0);
    check("abort_mw", 64'(ram3_mw), 64'd0);
    check("abort_wd", 64'(ram3_wd), 64'd0);
    check("abort_acks", 64'(acks), 64'd0);
    check("abort_m0_rd", 64'(if3_m0.rd), 64'd0);
    drv(3, 1'b0, 2'b00, 32'h20, 32'h0);
    n_reset = 1'b1;
    wait_cyc(3);

    // Fresh request after the abort completes normally.
    t = cyc;
    drv(3, 1'b1, 2'b00, 32'h20, 32'h0);
    push(3, 32'hCAFEF00D, t + 4);
    wait_cyc(5);
    drv(3, 1'b0, 2'b00, 32'h20, 32'h0);
    wait_cyc(3);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
